// File: rtl/cache_mem_arbiter_pkg.sv
// cache_pkg: shared arbiter state encodings and cache line geometry
package cache_pkg;
  localparam int LINE_BEATS = 8;
  localparam int OFFSET_W = 5;
  typedef enum logic [1:0] {IDLE, IC_RD, DC_RD, DC_WR} arb_state_e;
  typedef enum logic {ADDR, WAIT} arb_phase_e;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: icache, dcache and sram-like memory signals around the arbiter
interface cache_mem_arbiter_if #(parameter int ADDR_W = 32);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_gnt, ic_rvalid, ic_last;
  logic [31:0]       ic_rdata;
  logic              dc_req, dc_wr;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_wdata;
  logic              dc_gnt, dc_wready, dc_rvalid, dc_last, dc_bdone;
  logic [31:0]       dc_rdata;
  logic              m_req, m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic              m_addr_ok, m_data_ok;
  logic [31:0]       m_rdata;
  modport master (
    output ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, m_addr_ok, m_data_ok, m_rdata,
    input  ic_gnt, ic_rvalid, ic_rdata, ic_last, dc_gnt, dc_wready, dc_rvalid, dc_rdata,
           dc_last, dc_bdone, m_req, m_wr, m_addr, m_wdata
  );
  modport slave (
    input  ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, m_addr_ok, m_data_ok, m_rdata,
    output ic_gnt, ic_rvalid, ic_rdata, ic_last, dc_gnt, dc_wready, dc_rvalid, dc_rdata,
           dc_last, dc_bdone, m_req, m_wr, m_addr, m_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter_rr.sv
// cache_arb_rr: two-input round-robin picker (bit 0 icache, bit 1 dcache) with last-served register
module cache_arb_rr (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_q, last_d;
  always_comb begin
    gnt = en ? ((req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req) : 2'b00;
    last_d = (gnt == 2'b00) ? last_q : gnt[1];
  end
  // Reset marks icache as last served so dcache wins the first tie
  always_ff @(posedge clk) last_q <= !resetn ? 1'b0 : last_d;
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: arbitrates icache/dcache line bursts onto one sram-like memory port
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_BEATS = cache_pkg::LINE_BEATS
) (
  input logic clk,
  input logic resetn,
  cache_mem_arbiter_if.slave bus
);
  import cache_pkg::*;
  arb_state_e        state_q, state_d;
  arb_phase_e        phase_q, phase_d;
  logic [2:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              first_q, first_d;
  logic [1:0]        pick;
  logic              last_beat, addr_acc, data_acc;
  cache_arb_rr u_rr (
    .clk(clk), .resetn(resetn), .en(state_q == IDLE), .req({bus.dc_req, bus.ic_req}), .gnt(pick)
  );
  always_comb begin
    last_beat = beat_q == 3'(LINE_BEATS - 1);
    addr_acc = state_q != IDLE && phase_q == ADDR && bus.m_addr_ok;
    data_acc = state_q != IDLE && phase_q == WAIT && bus.m_data_ok;
    state_d = state_q;
    phase_d = phase_q;
    beat_d = beat_q;
    addr_d = addr_q;
    first_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = pick[1] ? (bus.dc_wr ? DC_WR : DC_RD) : (pick[0] ? IC_RD : IDLE);
      addr_d = pick[1] ? bus.dc_addr : (pick[0] ? bus.ic_addr : addr_q);
      phase_d = ADDR;
      first_d = |pick;
    end else if (addr_acc) begin
      phase_d = WAIT;
    end else if (data_acc) begin
      phase_d = ADDR;
      beat_d = beat_q + 3'd1;
      state_d = last_beat ? IDLE : state_q;
    end
  end
  // Beat address wraps inside the line, critical word first
  always_comb begin
    bus.m_req = state_q != IDLE && phase_q == ADDR;
    bus.m_wr = bus.m_req && state_q == DC_WR;
    bus.m_addr = bus.m_req ? {addr_q[ADDR_W-1:OFFSET_W], addr_q[OFFSET_W-1:2] + beat_q, 2'b00} : '0;
    bus.m_wdata = bus.m_wr ? bus.dc_wdata : '0;
    bus.ic_gnt = first_q && state_q == IC_RD;
    bus.dc_gnt = first_q && (state_q == DC_RD || state_q == DC_WR);
    bus.ic_rvalid = data_acc && state_q == IC_RD;
    bus.dc_rvalid = data_acc && state_q == DC_RD;
    bus.ic_rdata = bus.ic_rvalid ? bus.m_rdata : '0;
    bus.dc_rdata = bus.dc_rvalid ? bus.m_rdata : '0;
    bus.ic_last = bus.ic_rvalid && last_beat;
    bus.dc_last = bus.dc_rvalid && last_beat;
    bus.dc_wready = addr_acc && state_q == DC_WR;
    bus.dc_bdone = data_acc && state_q == DC_WR && last_beat;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      phase_q <= ADDR;
      beat_q <= '0;
      addr_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      beat_q <= beat_d;
      addr_q <= addr_d;
      first_q <= first_d;
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench with a simple memory model for the line-burst arbiter
module tb_cache_mem_arbiter;
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } tx_t;
  typedef struct { logic [31:0] data; logic last; } rd_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  cache_mem_arbiter_if #(.ADDR_W(32)) a ();
  cache_mem_arbiter #(.ADDR_W(32), .LINE_BEATS(8)) dut (.clk(clk), .resetn(resetn), .bus(a));
  always #5 clk = ~clk;

  tx_t exp_tx[$];
  rd_t exp_ic[$];
  rd_t exp_dc[$];
  bit  exp_gnt[$];
  int passed = 0, total = 0, cyc = 0;
  int ic_cnt = 0, bdone_cnt = 0, wbeat = 0, dly_cnt = 0;
  int ic_gnt_cyc = 0, dc_end_cyc = 0, bdone_cyc = 0, last_acc_cyc = 0;
  int addr_dly = 0;
  bit spur = 0, mem_en = 1, force_dok = 0, pend = 0, prev_gnt = 0, hold_v = 0;
  logic [31:0] paddr, hold_a;
  tx_t t;
  rd_t r;
  logic out_any;
  assign out_any = |{a.ic_gnt, a.ic_rvalid, a.ic_rdata, a.ic_last, a.dc_gnt, a.dc_wready,
                     a.dc_rvalid, a.dc_rdata, a.dc_last, a.dc_bdone, a.m_req, a.m_wr,
                     a.m_addr, a.m_wdata};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input int i);
    return (base & ~32'h1F) | ((base + 32'(4 * i)) & 32'h1C);
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] ad);
    return ad ^ 32'hC0DE_0000;
  endfunction

  // who: 0 icache refill, 1 dcache refill, 2 dcache writeback
  task automatic expect_burst(input int who, input logic [31:0] base);
    tx_t x;
    rd_t d;
    exp_gnt.push_back(who != 0);
    for (int i = 0; i < 8; i++) begin
      x.addr = beat_addr(base, i);
      x.wr = (who == 2);
      x.wdata = 32'hA0 + 32'(i);
      exp_tx.push_back(x);
      d.data = mem_data(x.addr);
      d.last = (i == 7);
      if (who == 0) exp_ic.push_back(d);
      if (who == 1) exp_dc.push_back(d);
    end
  endtask

  // Memory model: addr_ok after addr_dly stalled cycles, data_ok one cycle after acceptance
  initial begin
    a.m_addr_ok = 0; a.m_data_ok = 0; a.m_rdata = 0; a.dc_wdata = 32'hA0;
    forever begin
      @(posedge clk); #1;
      a.dc_wdata = 32'hA0 + 32'(wbeat);
      a.m_addr_ok = 0; a.m_data_ok = 0; a.m_rdata = 0;
      if (!mem_en) begin
        a.m_data_ok = force_dok; a.m_rdata = 32'h1234_5678; pend = 0; dly_cnt = 0;
      end else if (pend) begin
        a.m_data_ok = 1; a.m_rdata = mem_data(paddr);
      end else if (a.m_req) begin
        if (dly_cnt < addr_dly) begin
          dly_cnt++;
          if (spur) begin a.m_data_ok = 1; a.m_rdata = 32'hDEAD_BEEF; end
        end else begin
          a.m_addr_ok = 1; dly_cnt = 0;
        end
      end
      @(negedge clk);
      if (a.dc_wready) wbeat++;
      if (mem_en) begin
        if (pend) pend = 0;
        else if (a.m_req && a.m_addr_ok) begin pend = 1; paddr = a.m_addr; end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transaction, beat or grant
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!resetn) begin hold_v = 0; prev_gnt = 0; continue; end
    if (hold_v) begin chk("hold_m_req", a.m_req, 1); chk("hold_m_addr", a.m_addr, hold_a); end
    hold_v = a.m_req && !a.m_addr_ok;
    hold_a = a.m_addr;
    if (a.m_req && a.m_data_ok) chk("spurious_rvalid", {a.ic_rvalid, a.dc_rvalid}, 0);
    if (a.m_req && a.m_addr_ok) begin
      last_acc_cyc = cyc;
      if (exp_tx.size() == 0) chk("unexpected_tx", a.m_req, 0);
      else begin
        t = exp_tx.pop_front();
        chk("m_addr", a.m_addr, t.addr);
        chk("m_wr", a.m_wr, t.wr);
        chk("dc_wready", a.dc_wready, t.wr);
        if (t.wr) chk("m_wdata", a.m_wdata, t.wdata);
      end
    end
    if (a.ic_rvalid) begin
      ic_cnt++;
      if (exp_ic.size() == 0) chk("unexpected_ic_rvalid", a.ic_rvalid, 0);
      else begin
        r = exp_ic.pop_front();
        chk("ic_rdata", a.ic_rdata, r.data);
        chk("ic_last", a.ic_last, r.last);
      end
    end
    if (a.dc_rvalid) begin
      if (exp_dc.size() == 0) chk("unexpected_dc_rvalid", a.dc_rvalid, 0);
      else begin
        r = exp_dc.pop_front();
        chk("dc_rdata", a.dc_rdata, r.data);
        chk("dc_last", a.dc_last, r.last);
      end
      if (a.dc_last) dc_end_cyc = cyc;
    end
    if (a.dc_bdone) begin bdone_cnt++; bdone_cyc = cyc; end
    if (a.ic_gnt || a.dc_gnt) begin
      if (a.ic_gnt) ic_gnt_cyc = cyc;
      chk("gnt_single_cycle", prev_gnt, 0);
      if (exp_gnt.size() == 0) chk("unexpected_gnt", {a.ic_gnt, a.dc_gnt}, 0);
      else chk("gnt_who", {a.ic_gnt, a.dc_gnt}, exp_gnt.pop_front() ? 2'b01 : 2'b10);
    end
    prev_gnt = a.ic_gnt || a.dc_gnt;
  end

  task automatic do_reset();
    @(negedge clk); #1 resetn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", out_any, 0);
    #1 resetn = 1;
  endtask

  task automatic hold_until_gnt(input bit dc);
    int n = 0;
    while (!(dc ? a.dc_gnt : a.ic_gnt) && n < 100) begin @(negedge clk); #1; n++; end
    chk(dc ? "dc_gnt_seen" : "ic_gnt_seen", n < 100, 1);
    if (dc) a.dc_req = 0; else a.ic_req = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_tx.size() + exp_ic.size() + exp_dc.size() + exp_gnt.size() != 0 || a.m_req) && n < 400) begin
      @(negedge clk); #1; n++;
    end
    chk({name, "_completed"}, n < 400, 1);
    exp_tx.delete(); exp_ic.delete(); exp_dc.delete(); exp_gnt.delete();
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int c0;
    a.ic_req = 0; a.ic_addr = 0; a.dc_req = 0; a.dc_wr = 0; a.dc_addr = 0;
    do_reset();
    // Icache refill alone, critical word first from 0x1014
    expect_burst(0, 32'h1014);
    @(negedge clk); #1 a.ic_req = 1; a.ic_addr = 32'h1014; c0 = cyc;
    hold_until_gnt(0);
    a.ic_addr = 32'h0;
    drain("ic_refill");
    chk("ic_gnt_latency", ic_gnt_cyc, c0 + 1);
    // Simultaneous requests out of reset: dcache first, icache after one idle cycle
    do_reset();
    expect_burst(1, 32'h3008);
    expect_burst(0, 32'h4000);
    @(negedge clk); #1;
    a.dc_req = 1; a.dc_wr = 0; a.dc_addr = 32'h3008; a.ic_req = 1; a.ic_addr = 32'h4000;
    hold_until_gnt(1);
    hold_until_gnt(0);
    drain("both_req");
    chk("ic_gnt_after_idle", ic_gnt_cyc, dc_end_cyc + 2);
    // Dcache writeback
    c0 = bdone_cnt;
    expect_burst(2, 32'h2000_0000);
    a.dc_req = 1; a.dc_wr = 1; a.dc_addr = 32'h2000_0000;
    hold_until_gnt(1);
    drain("writeback");
    chk("dc_wready_pulses", wbeat, 8);
    chk("dc_bdone_once", bdone_cnt - c0, 1);
    chk("dc_bdone_timing", bdone_cyc, last_acc_cyc + 1);
    // Stalled addr_ok with spurious data_ok in ADDR phase
    addr_dly = 3; spur = 1;
    expect_burst(0, 32'h5010);
    a.ic_req = 1; a.ic_addr = 32'h5010;
    hold_until_gnt(0);
    drain("stalled_refill");
    addr_dly = 0; spur = 0;
    // Reset in the middle of an icache refill
    expect_burst(0, 32'h6000);
    c0 = ic_cnt;
    a.ic_req = 1; a.ic_addr = 32'h6000;
    hold_until_gnt(0);
    for (int n = 0; n < 100 && ic_cnt < c0 + 4; n++) begin @(negedge clk); #1; end
    chk("beats_before_reset", ic_cnt - c0, 4);
    @(negedge clk); #1;
    resetn = 0; mem_en = 0; force_dok = 1;
    exp_tx.delete(); exp_ic.delete(); exp_dc.delete(); exp_gnt.delete();
    @(negedge clk);
    chk("abort_outputs_zero", out_any, 0);
    #1 resetn = 1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("late_data_ok_no_rvalid", a.ic_rvalid, 0);
      chk("late_no_m_req", a.m_req, 0);
    end
    #1 mem_en = 1; force_dok = 0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end
endmodule
